// File: rtl/multi_shifter_if.sv
// Request/result bundle for multi_shifter: operand, op code and distance in;
// result, busy and completion pulse out.
interface multi_shifter_if;
    logic        start;
    logic [15:0] in;
    logic [1:0]  shift;
    logic [3:0]  amt;
    logic [15:0] sout;
    logic        busy;
    logic        done;

    modport master (
        output start, in, shift, amt,
        input  sout, busy, done
    );

    modport slave (
        input  start, in, shift, amt,
        output sout, busy, done
    );
endinterface

// File: rtl/multi_shifter.sv
// Sequential 16-bit shifter, one bit per cycle: pass, logical left/right, arithmetic right.
// Define MULTI_SHIFTER_ROTATE_EN to make op 11 a rotate right instead of an arithmetic right shift.
module multi_shifter (
    input  logic          clk,
    input  logic          reset_n,
    multi_shifter_if.slave bus
);
    localparam int unsigned W  = 16;
    localparam int unsigned CW = 4;
    localparam int unsigned OW = 2;

    localparam logic [OW-1:0] OP_PASS = 2'b00;
    localparam logic [OW-1:0] OP_LSL  = 2'b01;
    localparam logic [OW-1:0] OP_LSR  = 2'b10;
    localparam logic [OW-1:0] OP_ASR  = 2'b11;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  sout_q, sout_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [OW-1:0] op_q, op_d;
    logic          busy_q, done_q;

    // Next-state and datapath; a zero distance or pass op completes in one cycle
    always_comb begin
        state_d = state_q;
        sout_d  = sout_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    sout_d  = bus.in;
                    op_d    = bus.shift;
                    cnt_d   = bus.amt;
                    state_d = (bus.amt == CW'(0) || bus.shift == OP_PASS) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                case (op_q)
                    OP_LSL:  sout_d = {sout_q[W-2:0], 1'b0};
                    OP_LSR:  sout_d = {1'b0, sout_q[W-1:1]};
`ifdef MULTI_SHIFTER_ROTATE_EN
                    OP_ASR:  sout_d = {sout_q[0], sout_q[W-1:1]};
`else
                    OP_ASR:  sout_d = {sout_q[W-1], sout_q[W-1:1]};
`endif
                    default: sout_d = sout_q;
                endcase
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; busy/done follow the state being entered
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            sout_q  <= '0;
            cnt_q   <= '0;
            op_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sout_q  <= sout_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            busy_q  <= (state_d != IDLE);
            done_q  <= (state_d == DONE);
        end
    end

    assign bus.sout = sout_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule

// File: tb/tb_multi_shifter.sv
// Scoreboard bench for multi_shifter: directed ops push expected results, a
// negedge monitor checks result, completion cycle, busy, hold and reset values.
module tb_multi_shifter;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;

    multi_shifter_if bus ();

    multi_shifter dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] sout;
        int          e0;
        int          n;
    } exp_t;

    exp_t        q[$];
    int          tests = 0;
    int          fails = 0;
    bit          tout = 1'b0;
    bit          end_req = 1'b0;
    logic [15:0] hold_val = 16'h0000;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares on every falling edge, decoupled from stimulus
    always @(negedge clk) begin
        exp_t e;
        if (end_req) begin
            check("queue_drained", 32'(q.size()), 32'd0);
            check("no_timeout", 32'(tout), 32'd0);
            $display("[TB] %0d tests run, %0d failed", tests, fails);
            $finish;
        end else if (!reset_n) begin
            check("rst_sout", 32'(bus.sout), 32'h0);
            check("rst_busy", 32'(bus.busy), 32'h0);
            check("rst_done", 32'(bus.done), 32'h0);
            hold_val = 16'h0000;
        end else if (bus.done) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got done=1 expected done=0 (cycle %0d)", cyc);
            end else begin
                e = q.pop_front();
                check("sout", 32'(bus.sout), 32'(e.sout));
                check("done_cycle", 32'(cyc), 32'(e.e0 + e.n + 1));
                check("busy_at_done", 32'(bus.busy), 32'h1);
                hold_val = e.sout;
            end
        end else if (q.size() != 0 && cyc >= q[0].e0 + 1) begin
            check("busy_during_op", 32'(bus.busy), 32'h1);
        end else if (!bus.busy) begin
            check("sout_hold", 32'(bus.sout), 32'(hold_val));
        end
    end

    // Issue one request; start stays high for hold extra edges while inputs are scrambled
    task automatic issue(input logic [15:0] din, input logic [1:0] sh, input logic [3:0] a,
                         input logic [15:0] exp, input bit push, input int hold);
        int waited = 0;
        exp_t e;
        @(negedge clk);
        while (bus.busy && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (bus.busy) tout = 1'b1;
        bus.start = 1'b1;
        bus.in    = din;
        bus.shift = sh;
        bus.amt   = a;
        if (push) begin
            e.sout = exp;
            e.e0   = cyc;
            e.n    = (sh == 2'b00) ? 0 : int'(a);
            q.push_back(e);
        end
        for (int i = 0; i <= hold; i++) begin
            @(negedge clk);
            bus.in    = ~bus.in;
            bus.shift = ~bus.shift;
            bus.amt   = ~bus.amt;
        end
        bus.start = 1'b0;
    endtask

    initial begin
        int waited;
        bus.start = 1'b0;
        bus.in    = 16'h0000;
        bus.shift = 2'b00;
        bus.amt   = 4'd0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        issue(16'h8001, 2'b01, 4'd3,  16'h0008, 1'b1, 0);
`ifdef MULTI_SHIFTER_ROTATE_EN
        issue(16'h8000, 2'b11, 4'd4,  16'h0800, 1'b1, 0);
        issue(16'h0001, 2'b11, 4'd1,  16'h8000, 1'b1, 0);
        issue(16'h7FFF, 2'b11, 4'd15, 16'hFFFE, 1'b1, 0);
        issue(16'hC000, 2'b11, 4'd1,  16'h6000, 1'b1, 0);
`else
        issue(16'h8000, 2'b11, 4'd4,  16'hF800, 1'b1, 0);
        issue(16'h0001, 2'b11, 4'd1,  16'h0000, 1'b1, 0);
        issue(16'h7FFF, 2'b11, 4'd15, 16'h0000, 1'b1, 0);
        issue(16'hC000, 2'b11, 4'd1,  16'hE000, 1'b1, 0);
`endif
        issue(16'hFFFF, 2'b10, 4'd15, 16'h0001, 1'b1, 0);
        issue(16'h1234, 2'b01, 4'd0,  16'h1234, 1'b1, 0);
        issue(16'hABCD, 2'b00, 4'd9,  16'hABCD, 1'b1, 0);
        issue(16'h00F0, 2'b10, 4'd4,  16'h000F, 1'b1, 0);
        issue(16'h8001, 2'b10, 4'd1,  16'h4000, 1'b1, 0);
        // start held through the whole amt=5 run, including the DONE cycle
        issue(16'h0003, 2'b01, 4'd5,  16'h0060, 1'b1, 6);

        // Reset dropped shortly after E0+2 aborts the run with no done
        issue(16'h1111, 2'b01, 4'd5,  16'h0000, 1'b0, 0);
        @(posedge clk);
        @(posedge clk);
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        issue(16'h0F0F, 2'b01, 4'd4,  16'hF0F0, 1'b1, 0);

        waited = 0;
        while (q.size() != 0 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (q.size() != 0) tout = 1'b1;
        repeat (6) @(negedge clk);
        #1 end_req = 1'b1;
    end
endmodule

// File: doc/multi_shifter.md
MULTI_SHIFTER -- requirements
Module: multi_shifter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk  input  1  rising-edge clock for all state.
REQ-002 reset_n  input  1  asynchronous active-low reset; asserting it forces reset values immediately, independent of clk.
REQ-003 start  input  1  request; sampled only in IDLE.
REQ-004 in  input  16  operand; captured on the accepted start edge.
REQ-005 shift  input  2  op code; captured with in: 00 pass, 01 logical left, 10 logical right, 11 arithmetic right (MSB replicated).
REQ-006 amt  input  4  shift distance 0..15; captured with in.
REQ-007 sout  output  16  result register; holds its value until the next accepted start.
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 done  output  1  single-cycle completion pulse.

Function
REQ-010 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-011 In IDLE, start=1 at a clk edge (E0) SHALL load sout<=in, op<=shift and cnt<=amt.
REQ-012 On that edge, the FSM SHALL go to DONE if amt==0 or shift==00, and to SHIFT otherwise.
REQ-013 In SHIFT, each edge SHALL apply one 1-bit step of op to sout and decrement cnt.
REQ-014 In SHIFT, the edge on which cnt==1 SHALL move the FSM to DONE.
REQ-015 A logical-left step SHALL fill bit 0 with 0.
REQ-016 A logical-right step SHALL fill bit 15 with 0.
REQ-017 An arithmetic-right step SHALL fill bit 15 with the current sout[15].
REQ-018 done SHALL be high exactly during the cycle between edges E0+n and E0+n+1, where n=amt, or n=0 when shift==00.
REQ-019 DONE SHALL return to IDLE on the next edge unconditionally.
REQ-020 start SHALL be ignored while busy=1, including in the DONE cycle; no queuing.
REQ-021 Changes on in, shift or amt after E0 SHALL NOT affect the operation in progress.
REQ-022 sout SHALL change only on an accepted start, on SHIFT steps, or on reset.
REQ-023 sout SHALL be stable and valid whenever done=1.

Reset
REQ-024 While reset_n=0, the block SHALL hold state=IDLE, sout=16'h0000, cnt=0, op=00, busy=0 and done=0.
REQ-025 Reset asserted mid-operation SHALL abort the operation with no done pulse.
REQ-026 After reset_n rises, the first start SHALL be accepted normally.

Configuration
REQ-027 With macro MULTI_SHIFTER_ROTATE_EN defined, op 11 SHALL rotate right one bit per step, with old bit 0 moving to bit 15.
REQ-028 With MULTI_SHIFTER_ROTATE_EN undefined, op 11 SHALL be an arithmetic right shift per REQ-017.
REQ-029 All other ops, timing and reset behaviour SHALL be identical in both builds.

Verification
REQ-030 Logical left: in=16'h8001, shift=01, amt=3 -> sout=16'h0008, done high between E0+3 and E0+4, busy high from E0 through end of done.
REQ-031 Arithmetic right (macro undefined): in=16'h8000, shift=11, amt=4 -> sout=16'hF800.
REQ-032 Rotate (macro defined): in=16'h0001, shift=11, amt=1 -> sout=16'h8000; macro undefined -> 16'h0000.
REQ-033 Full distance: in=16'hFFFF, shift=10, amt=15 -> sout=16'h0001 after 15 steps.
REQ-034 Bypass paths:
- amt=0, in=16'h1234, shift=01 -> sout=16'h1234, done in cycle after E0.
- shift=00, amt=9 -> same 1-cycle completion.
REQ-035 Robustness:
- start pulsed every cycle during an amt=5 operation -> ignored; exactly one done.
- reset_n dropped at E0+2 -> sout=0, busy=0, no done.
